// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and hold-length helper for the
// instruction sequencer that feeds simple_cpu.
package cpu_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int CNT_W           = 8;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Cycles an instruction of class cls is held, clamped to [1, 2^CNT_W-1].
  function automatic logic [CNT_W-1:0] hold_of(input logic [1:0] cls,
                                               input int hold_std,
                                               input int hold_load,
                                               input int hold_store);
    int h;
    case (cls)
      CLS_STD:   h = hold_std;
      CLS_LOAD:  h = hold_load;
      CLS_STORE: h = hold_store;
      default:   h = 1;
    endcase
    if (h < 1) begin
      hold_of = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (h > (2**CNT_W) - 1) begin
      hold_of = {CNT_W{1'b1}};
    end else begin
      hold_of = h[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load, control and instruction-issue signals between a host
// (master) and the instruction sequencer (slave).
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = cpu_pkg::DEF_INSTR_WIDTH,
  parameter int PC_BITS     = 4
);
  logic                   prog_we;
  logic [PC_BITS-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic                   halt_req;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;
  logic [PC_BITS:0]       issued_cnt;

  modport master (
    output prog_we, prog_addr, prog_data, start, halt_req,
    input  instruction, pc, busy, done, issued_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, halt_req,
    output instruction, pc, busy, done, issued_cnt
  );
endinterface

// File: rtl/instr_mem.sv
// Program store: synchronous write, two asynchronous read ports, no reset.
module instr_mem #(
  parameter int INSTR_WIDTH = cpu_pkg::DEF_INSTR_WIDTH,
  parameter int PC_BITS     = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [PC_BITS-1:0]     raddr_a,
  output logic [INSTR_WIDTH-1:0] rdata_a,
  input  logic [PC_BITS-1:0]     raddr_b,
  output logic [INSTR_WIDTH-1:0] rdata_b
);
  logic [INSTR_WIDTH-1:0] mem_r [2**PC_BITS];

  // Program word write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];
endmodule

// File: rtl/instr_sequencer.sv
// Issues program words to simple_cpu one at a time, holding each for the
// number of cycles its class spends in the CPU's control unit.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = 4,
  parameter int HOLD_STD    = 3,
  parameter int HOLD_LOAD   = 4,
  parameter int HOLD_STORE  = 4
) (
  input logic             clk,
  input logic             rst,
  instr_sequencer_if.slave bus
);
  localparam int               CLS_HI = INSTR_WIDTH - 1;
  localparam logic [PC_BITS-1:0] PC_MAX = {PC_BITS{1'b1}};

  seq_state_e             state_r;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [PC_BITS-1:0]     pc_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [PC_BITS:0]       issued_r;
  logic                   halt_pend_r;

  logic                   mem_we_s;
  logic [INSTR_WIDTH-1:0] mem0_s;
  logic [INSTR_WIDTH-1:0] next_word_s;
  logic [INSTR_WIDTH-1:0] first_word_s;
  logic [PC_BITS-1:0]     pc_next_s;

  assign mem_we_s  = bus.prog_we && (state_r != RUN);
  assign pc_next_s = pc_r + PC_BITS'(1);

  instr_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_BITS     (PC_BITS)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we_s),
    .waddr   (bus.prog_addr),
    .wdata   (bus.prog_data),
    .raddr_a ({PC_BITS{1'b0}}),
    .rdata_a (mem0_s),
    .raddr_b (pc_next_s),
    .rdata_b (next_word_s)
  );

  // A same-cycle write to address 0 must be the word a start launches.
  always_comb begin
    first_word_s = mem0_s;
    if (mem_we_s && (bus.prog_addr == {PC_BITS{1'b0}})) begin
      first_word_s = bus.prog_data;
    end else begin
      first_word_s = mem0_s;
    end
  end

  // Sequencer FSM with hold counter, pc and issue count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      instr_r     <= {INSTR_WIDTH{1'b0}};
      pc_r        <= {PC_BITS{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      issued_r    <= {(PC_BITS+1){1'b0}};
      halt_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            pc_r <= {PC_BITS{1'b0}};
            if (first_word_s[CLS_HI -: 2] == CLS_NOP) begin
              issued_r <= {(PC_BITS+1){1'b0}};
              state_r  <= DONE;
            end else begin
              instr_r  <= first_word_s;
              cnt_r    <= hold_of(first_word_s[CLS_HI -: 2], HOLD_STD, HOLD_LOAD,
                                  HOLD_STORE) - CNT_W'(1);
              issued_r <= (PC_BITS+1)'(1);
              state_r  <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.halt_req) begin
            halt_pend_r <= 1'b1;
          end
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else if (halt_pend_r || bus.halt_req || (pc_r == PC_MAX) ||
                       (next_word_s[CLS_HI -: 2] == CLS_NOP)) begin
            instr_r <= {INSTR_WIDTH{1'b0}};
            state_r <= DONE;
          end else begin
            pc_r     <= pc_next_s;
            instr_r  <= next_word_s;
            cnt_r    <= hold_of(next_word_s[CLS_HI -: 2], HOLD_STD, HOLD_LOAD,
                                HOLD_STORE) - CNT_W'(1);
            issued_r <= issued_r + (PC_BITS+1)'(1);
          end
        end
        DONE: begin
          halt_pend_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.instruction = instr_r;
  assign bus.pc          = pc_r;
  assign bus.busy        = (state_r == RUN);
  assign bus.done        = (state_r == DONE);
  assign bus.issued_cnt  = issued_r;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand
// sequences for reset/halt/write corner cases, and randomized programs.
module tb_instr_sequencer;
  localparam int W  = 20;
  localparam int PB = 4;

  typedef logic [30:0] obs_t;  // {instruction, pc, busy, done, issued_cnt}

  typedef struct {
    logic          we;
    logic [PB-1:0] addr;
    logic [W-1:0]  data;
    logic          start;
    logic          halt;
    obs_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_sequencer_if #(.INSTR_WIDTH(W), .PC_BITS(PB)) sif ();

  instr_sequencer #(
    .INSTR_WIDTH (W),
    .PC_BITS     (PB),
    .HOLD_STD    (3),
    .HOLD_LOAD   (4),
    .HOLD_STORE  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] model_mem [16];
  obs_t        exp_q [$];
  vec_t        tbl [16];

  function automatic obs_t pack(input logic [W-1:0] ins, input logic [PB-1:0] p,
                                input logic b, input logic dn, input logic [PB:0] c);
    return {ins, p, b, dn, c};
  endfunction

  function automatic obs_t observed();
    return {sif.instruction, sif.pc, sif.busy, sif.done, sif.issued_cnt};
  endfunction

  function automatic vec_t mk(input logic we, input logic [PB-1:0] a, input logic [W-1:0] d,
                              input logic st, input obs_t e);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.start = st; v.halt = 1'b0; v.exp = e;
    return v;
  endfunction

  // Hold length straight from the class field; 0 marks end of program.
  function automatic int hold_cycles(input logic [W-1:0] w);
    case (w[19:18])
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got instr=%h pc=%0d busy=%b done=%b cnt=%0d, want instr=%h pc=%0d busy=%b done=%b cnt=%0d",
               name, act[30:11], act[10:7], act[6], act[5], act[4:0],
               exp[30:11], exp[10:7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic cycle(input logic we, input logic [PB-1:0] a, input logic [W-1:0] d,
                       input logic st, input logic h);
    sif.prog_we = we; sif.prog_addr = a; sif.prog_data = d;
    sif.start = st; sif.halt_req = h;
    @(posedge clk);
    @(negedge clk);
    sif.prog_we = 1'b0; sif.start = 1'b0; sif.halt_req = 1'b0;
  endtask

  task automatic write_word(input logic [PB-1:0] a, input logic [W-1:0] d);
    cycle(1'b1, a, d, 1'b0, 1'b0);
    model_mem[a] = d;
  endtask

  // Expected per-cycle outputs from the start edge on: each word repeated for
  // its hold length, stopping at a NOP, the top address or a requested halt.
  function automatic void build_trace(input int halt_j);
    int n;
    int last;
    n = 0; last = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (hold_cycles(model_mem[i]) == 0) break;
      n++; last = i;
      repeat (hold_cycles(model_mem[i]))
        exp_q.push_back(pack(model_mem[i], last[PB-1:0], 1'b1, 1'b0, n[PB:0]));
      if (halt_j >= 0 && halt_j < exp_q.size()) break;
    end
    exp_q.push_back(pack('0, last[PB-1:0], 1'b0, 1'b1, n[PB:0]));
    exp_q.push_back(pack('0, last[PB-1:0], 1'b0, 1'b0, n[PB:0]));
  endfunction

  task automatic run_trace(input string name, input int halt_j, input bit noise,
                           input bit we0, input logic [W-1:0] d0);
    int            run_len;
    logic          we, st;
    logic [PB-1:0] a;
    logic [W-1:0]  d;
    if (we0) model_mem[0] = d0;
    build_trace(halt_j);
    run_len = exp_q.size() - 2;
    for (int k = 0; k < exp_q.size(); k++) begin
      we = 1'b0; st = 1'b0; a = '0; d = '0;
      if (k == 0) begin
        st = 1'b1; we = we0; d = d0;
      end else if (noise && (k - 1) < run_len) begin
        we = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
        a = 4'($urandom_range(0, 15)); d = 20'($urandom);
      end
      cycle(we, a, d, st, (k > 0) && (k == halt_j + 1));
      check($sformatf("%s[%0d]", name, k), observed(), exp_q[k]);
    end
  endtask

  initial begin
    int len;
    int hj;
    logic [1:0] cls;
    sif.prog_we = 1'b0; sif.prog_addr = '0; sif.prog_data = '0;
    sif.start = 1'b0; sif.halt_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("reset", observed(), pack('0, '0, 1'b0, 1'b0, '0));
    rst = 1'b1;
    for (int i = 0; i < 16; i++) write_word(i[PB-1:0], '0);

    // Directed three-instruction program, cycle by cycle.
    tbl[0]  = mk(1'b1, 4'd0, 20'h51230, 1'b0, pack('0, 4'd0, 1'b0, 1'b0, 5'd0));
    tbl[1]  = mk(1'b1, 4'd1, 20'h94020, 1'b0, pack('0, 4'd0, 1'b0, 1'b0, 5'd0));
    tbl[2]  = mk(1'b1, 4'd2, 20'h62100, 1'b0, pack('0, 4'd0, 1'b0, 1'b0, 5'd0));
    tbl[3]  = mk(1'b1, 4'd3, 20'h00000, 1'b0, pack('0, 4'd0, 1'b0, 1'b0, 5'd0));
    tbl[4]  = mk(1'b0, 4'd0, 20'h0, 1'b1, pack(20'h51230, 4'd0, 1'b1, 1'b0, 5'd1));
    tbl[5]  = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h51230, 4'd0, 1'b1, 1'b0, 5'd1));
    tbl[6]  = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h51230, 4'd0, 1'b1, 1'b0, 5'd1));
    tbl[7]  = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h94020, 4'd1, 1'b1, 1'b0, 5'd2));
    tbl[8]  = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h94020, 4'd1, 1'b1, 1'b0, 5'd2));
    tbl[9]  = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h94020, 4'd1, 1'b1, 1'b0, 5'd2));
    tbl[10] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h94020, 4'd1, 1'b1, 1'b0, 5'd2));
    tbl[11] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h62100, 4'd2, 1'b1, 1'b0, 5'd3));
    tbl[12] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h62100, 4'd2, 1'b1, 1'b0, 5'd3));
    tbl[13] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h62100, 4'd2, 1'b1, 1'b0, 5'd3));
    tbl[14] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h00000, 4'd2, 1'b0, 1'b1, 5'd3));
    tbl[15] = mk(1'b0, 4'd0, 20'h0, 1'b0, pack(20'h00000, 4'd2, 1'b0, 1'b0, 5'd3));
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].start, tbl[i].halt);
      if (tbl[i].we) model_mem[tbl[i].addr] = tbl[i].data;
      check($sformatf("vec%0d", i), observed(), tbl[i].exp);
    end

    // Halt in the second cycle of the load at pc=1, then a clean rerun.
    run_trace("halt", 4, 1'b0, 1'b0, '0);
    run_trace("rerun", -1, 1'b0, 1'b0, '0);

    // Writes and starts during RUN are ignored; memory checked by a rerun.
    run_trace("noise", -1, 1'b1, 1'b0, '0);
    run_trace("after_noise", -1, 1'b0, 1'b0, '0);

    // Write to address 0 in the start cycle launches the new word.
    run_trace("wr_start", -1, 1'b0, 1'b1, 20'hB0001);

    // Reset mid-hold aborts; program memory survives.
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check("reset_run", observed(), pack('0, '0, 1'b0, 1'b0, '0));
    rst = 1'b1;
    run_trace("post_reset", -1, 1'b0, 1'b0, '0);

    // Empty program.
    write_word(4'd0, 20'h00000);
    run_trace("empty", -1, 1'b0, 1'b0, '0);

    // Full memory of std ops runs to the top address without wrapping.
    for (int i = 0; i < 16; i++) write_word(i[PB-1:0], {2'b01, 18'($urandom)});
    run_trace("full16", -1, 1'b0, 1'b0, '0);

    // Randomized programs, halts and RUN-time noise.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) begin
        cls = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        write_word(i[PB-1:0], {cls, 18'($urandom)});
      end
      build_trace(-1);
      len = exp_q.size() - 2;
      hj = (len == 0 || $urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
      run_trace($sformatf("rand%0d", it), hj, 1'b1, 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
